// File: rtl/xbar_route_seq_pkg.sv
// Shared crossbar types: flit width, direction indices, context-word layout and sequencer states.
package SMARTPkg;

    localparam int FLIT_W = 16;
    typedef logic [FLIT_W-1:0] FlitFixed;

    localparam int EAST  = 0;
    localparam int SOUTH = 1;
    localparam int WEST  = 2;
    localparam int NORTH = 3;
    localparam int ALU_T = 4;
    localparam int TREG  = 5;

    localparam int NUM_DIR  = 4;
    localparam int NUM_XIN  = 6;
    localparam int NUM_XOUT = 7;
    localparam int SEL_W    = 3;

    // Context word: seven 3-bit select codes from bit 0, bypass nibble on top
    localparam int CTXW_SEL_LSB = 0;
    localparam int CTXW_RB_LSB  = 21;
    localparam int CTXW_RB_W    = 4;
    localparam int CTXW_W       = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } route_state_e;

endpackage

// File: rtl/xbar_route_seq_decoder_onehot.sv
// 3-bit select code to 6-bit one-hot; codes 6 and 7 leave the output silent.
module decoder_onehot
    import SMARTPkg::*;
(
    input  logic [SEL_W-1:0]   code_i,
    output logic [NUM_XIN-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (code_i < SEL_W'(NUM_XIN)) begin
            onehot_o[code_i] = 1'b1;
        end
    end

endmodule

// File: rtl/xbar_route_seq.sv
// Crossbar route sequencer: steps through stored routing contexts, driving registered
// one-hot selects and bypass enables, and registers the flits entering the crossbar.
module xbar_route_seq
    import SMARTPkg::*;
#(
    parameter int NUM_CTX = 16,
    localparam int CTX_W  = $clog2(NUM_CTX)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i__cfg_wr_en,
    input  logic [CTX_W-1:0]                    i__cfg_wr_addr,
    input  logic [CTXW_W-1:0]                   i__cfg_wr_data,
    input  logic                                i__start,
    input  logic [CTX_W-1:0]                    i__last_ctx,
    input  logic                                i__loop,
    input  logic                                i__stall,
    input  logic                                i__abort,
    input  FlitFixed                            i__flit_nbr [NUM_DIR],
    input  FlitFixed                            i__flit_alu,
    input  FlitFixed                            i__flit_treg,
    output logic [NUM_XOUT-1:0][NUM_XIN-1:0]    o__sel,
    output logic [CTXW_RB_W-1:0]                o__regbypass,
    output FlitFixed                            o__data_in_local [NUM_DIR],
    output FlitFixed                            o__data_in_remote [NUM_XIN],
    output logic [CTX_W-1:0]                    o__ctx_idx,
    output logic                                o__busy,
    output logic                                o__done
);

    logic [CTXW_W-1:0] ctx_mem [NUM_CTX];

    route_state_e                       state_q, state_d;
    logic [CTX_W-1:0]                   ctx_q, ctx_d;
    logic [CTX_W-1:0]                   last_q, last_d;
    logic                               loop_q, loop_d;
    logic [NUM_XOUT-1:0][NUM_XIN-1:0]   sel_q, sel_d;
    logic [CTXW_RB_W-1:0]               rb_q, rb_d;
    FlitFixed                           remote_q [NUM_XIN];

    logic [CTX_W-1:0]                   load_idx;
    logic [CTXW_W-1:0]                  ld_word;
    logic [NUM_XOUT-1:0][NUM_XIN-1:0]   dec_sel;
    logic                               remote_en;

    // Context memory is deliberately outside reset so configuration survives it
    always_ff @(posedge clk) begin
        if (i__cfg_wr_en) begin
            ctx_mem[i__cfg_wr_addr] <= i__cfg_wr_data;
        end
    end

    // Index of the context loaded at the next advance: 0 on start or wrap, else ctx+1
    assign load_idx = (state_q == ST_RUN && ctx_q != last_q) ? ctx_q + CTX_W'(1) : '0;
    assign ld_word  = ctx_mem[load_idx];

    for (genvar g = 0; g < NUM_XOUT; g++) begin : g_dec
        decoder_onehot u_dec (
            .code_i   (ld_word[CTXW_SEL_LSB + SEL_W*g +: SEL_W]),
            .onehot_o (dec_sel[g])
        );
    end

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        last_d  = last_q;
        loop_d  = loop_q;
        sel_d   = sel_q;
        rb_d    = rb_q;
        case (state_q)
            ST_IDLE: begin
                if (i__start && !i__abort) begin
                    state_d = ST_RUN;
                    ctx_d   = '0;
                    last_d  = i__last_ctx;
                    loop_d  = i__loop;
                    sel_d   = dec_sel;
                    rb_d    = ld_word[CTXW_RB_LSB +: CTXW_RB_W];
                end
            end
            ST_RUN: begin
                if (i__abort) begin
                    state_d = ST_IDLE;
                    ctx_d   = '0;
                    sel_d   = '0;
                    rb_d    = '0;
                end else if (!i__stall) begin
                    if (ctx_q == last_q && !loop_q) begin
                        state_d = ST_DONE;
                        sel_d   = '0;
                        rb_d    = '0;
                    end else begin
                        ctx_d = load_idx;
                        sel_d = dec_sel;
                        rb_d  = ld_word[CTXW_RB_LSB +: CTXW_RB_W];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                rb_d    = '0;
            end
        endcase
    end

    assign remote_en = !(state_q == ST_RUN && i__stall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            sel_q   <= '0;
            rb_q    <= '0;
            for (int i = 0; i < NUM_XIN; i++) begin
                remote_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            sel_q   <= sel_d;
            rb_q    <= rb_d;
            if (remote_en) begin
                for (int d = 0; d < NUM_DIR; d++) begin
                    remote_q[d] <= i__flit_nbr[d];
                end
                remote_q[ALU_T] <= i__flit_alu;
                remote_q[TREG]  <= i__flit_treg;
            end
        end
    end

    assign o__data_in_local  = i__flit_nbr;
    assign o__data_in_remote = remote_q;
    assign o__sel            = sel_q;
    assign o__regbypass      = rb_q;
    assign o__ctx_idx        = ctx_q;
    assign o__busy           = (state_q == ST_RUN);
    assign o__done           = (state_q == ST_DONE);

endmodule

// File: doc/xbar_route_seq.md
XBAR_ROUTE_SEQ -- requirements
Module: xbar_route_seq

Interface
REQ-001 SHALL have parameter NUM_CTX, default 16, meaning the number of stored routing contexts (CTX_W = $clog2(NUM_CTX)).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port i__cfg_wr_en, input, 1, the context-memory write strobe.
REQ-005 SHALL have port i__cfg_wr_addr, input, CTX_W, the context index to write.
REQ-006 SHALL have port i__cfg_wr_data, input, 25, carrying [20:0] seven 3-bit encoded selects (output o at bits 3o+2:3o) and [24:21] the regbypass nibble.
REQ-007 SHALL have port i__start, input, 1, which begins a sequence.
REQ-008 SHALL have port i__last_ctx, input, CTX_W, the final context index; it is sampled at start.
REQ-009 SHALL have port i__loop, input, 1, which wraps to context 0 after i__last_ctx instead of finishing; it is sampled at start.
REQ-010 SHALL have port i__stall, input, 1, which freezes the sequence and the data registers.
REQ-011 SHALL have port i__abort, input, 1, which terminates the sequence.
REQ-012 SHALL have port i__flit_nbr, input, FlitFixed[4], carrying the neighbour flits indexed EAST/SOUTH/WEST/NORTH.
REQ-013 SHALL have port i__flit_alu, input, FlitFixed, the ALU result flit.
REQ-014 SHALL have port i__flit_treg, input, FlitFixed, the temp-register flit.
REQ-015 SHALL have port o__sel, output, 6 x 7, the one-hot input select per crossbar output.
REQ-016 SHALL have port o__regbypass, output, 4, the per-direction bypass enable.
REQ-017 SHALL have port o__data_in_local, output, FlitFixed[4], carrying the unregistered neighbour flits.
REQ-018 SHALL have port o__data_in_remote, output, FlitFixed[6], carrying the registered flits for E,S,W,N,ALU_T,TREG.
REQ-019 SHALL have port o__ctx_idx, output, CTX_W, the index of the context currently driven.
REQ-020 SHALL have port o__busy, output, 1, which is high in RUN.
REQ-021 SHALL have port o__done, output, 1, a one-cycle completion pulse.

Function
REQ-022 SHALL hold NUM_CTX x 25-bit context registers; a write lands at the clock edge and is readable the next cycle.
REQ-023 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-024 SHALL move IDLE->RUN on i__start: at that edge, ctx=0 and o__sel/o__regbypass load the decode of ctx 0.
REQ-025 SHALL, in RUN with i__stall=0, advance ctx every cycle: if ctx==last and loop=1, ctx wraps to 0; if ctx==last and loop=0, go to DONE; otherwise ctx+1; outputs reload from the new ctx at the same edge.
REQ-026 SHALL, in RUN with i__stall=1, hold ctx, o__sel, o__regbypass and all o__data_in_remote registers.
REQ-027 SHALL, on entry to DONE, zero o__sel/o__regbypass, assert o__done for exactly one cycle, and return to IDLE on the next edge.
REQ-028 SHALL, on i__abort in RUN, go to IDLE at the next edge with o__sel/o__regbypass zeroed and no o__done; abort takes priority over stall and advance.
REQ-029 SHALL ignore i__start in RUN and DONE.
REQ-030 SHALL ignore i__start when i__abort is simultaneously high in IDLE.
REQ-031 SHALL decode each 3-bit select: values 0-5 give a one-hot with bit n set; values 6-7 give all zeros (output silent).
REQ-032 SHALL latch a write to the currently driven context at that context's next load only; it never alters the outputs retroactively.
REQ-033 SHALL give o__data_in_local a zero-latency pass-through of i__flit_nbr.
REQ-034 SHALL register o__data_in_remote with 1-cycle latency from i__flit_nbr, i__flit_alu and i__flit_treg; the registers update in every state except RUN with stall.
REQ-035 SHALL, with i__last_ctx=0 and loop=0, produce RUN for exactly one cycle.

Reset
REQ-036 SHALL, on rst_n=0 at a clock edge, put the FSM in IDLE with ctx=0, o__sel all zero, o__regbypass=0, o__data_in_remote all zero, o__busy=0 and o__done=0.
REQ-037 SHALL preserve context memory contents across reset.
REQ-038 SHALL apply reset mid-RUN identically to reset from IDLE, with no o__done.

Structure
REQ-039 SHALL take FlitFixed and the direction constants EAST=0, SOUTH=1, WEST=2, NORTH=3, ALU_T=4, TREG=5 from SMARTPkg.
REQ-040 SHALL add the context-word field offsets and the state enum to SMARTPkg.
REQ-041 SHALL use one sub-module, decoder_onehot (3-bit to 6-bit with invalid->zero), instantiated 7 times; it is the inverse of encoder_onehot.

Verification
REQ-042 SHALL verify: write ctx0 sel[EAST]=3, regbypass=4'b0101, then start, last=0, loop=0 -> next cycle o__sel[EAST]=6'b001000, o__regbypass=4'b0101, busy=1; following cycle sel=0, done=1.
REQ-043 SHALL verify: last=2, loop=1, no stall for 7 cycles -> o__ctx_idx sequence 0,1,2,0,1,2,0 with busy constantly 1.
REQ-044 SHALL verify: stall held 3 cycles at ctx=1 -> ctx, sel and o__data_in_remote frozen, and o__data_in_local still tracks i__flit_nbr.
REQ-045 SHALL verify: a select code of 6 or 7 in any field -> the corresponding o__sel = 6'b000000.
REQ-046 SHALL verify: abort and stall asserted together at ctx=1 -> IDLE next cycle, sel=0, done never asserted.
REQ-047 SHALL verify: rst_n=0 mid-RUN, then restart -> all outputs zeroed, and the previously written contexts replay unchanged.
